lms_tap_sequencer: RTL and testbench

LMS_TAP_SEQUENCER -- requirements
Module: lms_tap_sequencer

---
 rtl/lms_pkg.sv | 22 ++
 rtl/lms_strobe_delay.sv | 32 +++
 rtl/lms_tap_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_lms_tap_sequencer.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/lms_pkg.sv
// Shared definitions for the LMS tap sequencer: state encoding, default geometry
// and the address-width helper.
package lms_pkg;

  localparam int NUM_TAPS_DEF = 32;
  localparam int MEM_LAT_DEF  = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FILTER,
    S_FDRAIN,
    S_ERROR,
    S_UPDATE,
    S_UDRAIN
  } state_t;

  function automatic int addr_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/lms_strobe_delay.sv
// DEPTH-stage shift register carrying {strobe, address}, used to align issue-time
// strobes with the read data coming back from the external memories.
module lms_strobe_delay #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned AW    = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          strobe,
  input  logic [AW-1:0] addr,
  output logic          strobe_dly,
  output logic [AW-1:0] addr_dly
);

  logic [AW:0] pipe [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0] <= {strobe, addr};
      for (int unsigned i = 1; i < DEPTH; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign {strobe_dly, addr_dly} = pipe[DEPTH-1];

endmodule

// File: rtl/lms_tap_sequencer.sv
// Control sequencer for a single-MAC LMS adaptive FIR: per sample it writes the
// sample buffer, runs the filter pass, latches the error and optionally adapts weights.
module lms_tap_sequencer
  import lms_pkg::*;
#(
  parameter int NUM_TAPS = NUM_TAPS_DEF,
  parameter int MEM_LAT  = MEM_LAT_DEF
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          ready_in,
  input  logic                          adapt_en_in,
  output logic                          x_wr_en_out,
  output logic [addr_w(NUM_TAPS)-1:0]   x_wr_addr_out,
  output logic [addr_w(NUM_TAPS)-1:0]   x_rd_addr_out,
  output logic [addr_w(NUM_TAPS)-1:0]   w_rd_addr_out,
  output logic                          w_wr_en_out,
  output logic [addr_w(NUM_TAPS)-1:0]   w_wr_addr_out,
  output logic                          mac_clr_out,
  output logic                          mac_en_out,
  output logic                          err_latch_out,
  output logic                          y_valid_out,
  output logic                          busy_out,
  output logic                          overrun_out,
  output logic [7:0]                    overrun_cnt_out
);

  localparam int AW = addr_w(NUM_TAPS);
  localparam logic [AW-1:0] LAST_TAP = AW'(NUM_TAPS - 1);
  localparam logic [AW-1:0] LAST_LAT = AW'(MEM_LAT - 1);

  state_t        state, state_next;
  logic [AW-1:0] cnt, cnt_next;
  logic [AW-1:0] head, head_next;

  logic          filter_issue, update_issue;
  logic          issuing;
  logic          x_wr_en_d, mac_clr_d, err_latch_d, busy_d, overrun_d;
  logic [AW-1:0] x_wr_addr_d, x_rd_addr_d, w_rd_addr_d;
  logic [7:0]    overrun_cnt_d;
  logic [AW-1:0] mac_pipe_addr, upd_pipe_addr, mac_tap_unused;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= S_IDLE;
      cnt   <= '0;
      head  <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      head  <= head_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    head_next  = head;
    case (state)
      S_IDLE: if (ready_in) state_next = S_LOAD;
      S_LOAD: begin
        state_next = S_FILTER;
        cnt_next   = '0;
      end
      S_FILTER: begin
        if (cnt == LAST_TAP) begin
          state_next = S_FDRAIN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + AW'(1);
        end
      end
      S_FDRAIN: begin
        if (cnt == LAST_LAT) begin
          state_next = S_ERROR;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + AW'(1);
        end
      end
      S_ERROR: begin
        cnt_next = '0;
        if (adapt_en_in) begin
          state_next = S_UPDATE;
        end else begin
          state_next = S_IDLE;
          head_next  = head + AW'(1);
        end
      end
      S_UPDATE: begin
        if (cnt == LAST_TAP) begin
          state_next = S_UDRAIN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + AW'(1);
        end
      end
      S_UDRAIN: begin
        if (cnt == LAST_LAT) begin
          state_next = S_IDLE;
          cnt_next   = '0;
          head_next  = head + AW'(1);
        end else begin
          cnt_next = cnt + AW'(1);
        end
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
    endcase

    // Outputs are decoded from the upcoming state so they register alongside it.
    issuing       = (state_next == S_FILTER) || (state_next == S_UPDATE);
    x_wr_en_d     = (state_next == S_LOAD);
    mac_clr_d     = (state_next == S_LOAD);
    x_wr_addr_d   = x_wr_en_d ? head : '0;
    x_rd_addr_d   = issuing ? (head - cnt_next) : '0;
    w_rd_addr_d   = issuing ? cnt_next : '0;
    err_latch_d   = (state_next == S_ERROR);
    busy_d        = (state_next != S_IDLE);
    overrun_d     = ready_in && (state != S_IDLE);
    overrun_cnt_d = overrun_cnt_out;
    if (overrun_d && (overrun_cnt_out != 8'hFF)) overrun_cnt_d = overrun_cnt_out + 8'd1;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      x_wr_en_out     <= 1'b0;
      x_wr_addr_out   <= '0;
      x_rd_addr_out   <= '0;
      w_rd_addr_out   <= '0;
      mac_clr_out     <= 1'b0;
      err_latch_out   <= 1'b0;
      y_valid_out     <= 1'b0;
      busy_out        <= 1'b0;
      overrun_out     <= 1'b0;
      overrun_cnt_out <= '0;
      filter_issue    <= 1'b0;
      update_issue    <= 1'b0;
    end else begin
      x_wr_en_out     <= x_wr_en_d;
      x_wr_addr_out   <= x_wr_addr_d;
      x_rd_addr_out   <= x_rd_addr_d;
      w_rd_addr_out   <= w_rd_addr_d;
      mac_clr_out     <= mac_clr_d;
      err_latch_out   <= err_latch_d;
      y_valid_out     <= err_latch_d;
      busy_out        <= busy_d;
      overrun_out     <= overrun_d;
      overrun_cnt_out <= overrun_cnt_d;
      filter_issue    <= (state_next == S_FILTER);
      update_issue    <= (state_next == S_UPDATE);
    end
  end

  assign mac_pipe_addr = filter_issue ? w_rd_addr_out : '0;
  assign upd_pipe_addr = update_issue ? w_rd_addr_out : '0;

  lms_strobe_delay #(
    .DEPTH (MEM_LAT),
    .AW    (AW)
  ) u_mac_delay (
    .clk        (clk_in),
    .rst        (rst_in),
    .strobe     (filter_issue),
    .addr       (mac_pipe_addr),
    .strobe_dly (mac_en_out),
    .addr_dly   (mac_tap_unused)
  );

  lms_strobe_delay #(
    .DEPTH (MEM_LAT),
    .AW    (AW)
  ) u_wr_delay (
    .clk        (clk_in),
    .rst        (rst_in),
    .strobe     (update_issue),
    .addr       (upd_pipe_addr),
    .strobe_dly (w_wr_en_out),
    .addr_dly   (w_wr_addr_out)
  );

endmodule

// File: tb/tb_lms_tap_sequencer.sv
// Bench for lms_tap_sequencer: a per-sample timeline model predicts every output
// each cycle from the offset since the accepting ready_in.
module tb_lms_tap_sequencer;

  localparam int N  = 32;
  localparam int L  = 1;
  localparam int AW = 5;
  localparam int E  = N + 2 + L;

  logic          clk_in = 1'b0;
  logic          rst_in, ready_in, adapt_en_in;
  logic          x_wr_en_out, w_wr_en_out, mac_clr_out, mac_en_out;
  logic          err_latch_out, y_valid_out, busy_out, overrun_out;
  logic [AW-1:0] x_wr_addr_out, x_rd_addr_out, w_rd_addr_out, w_wr_addr_out;
  logic [7:0]    overrun_cnt_out;

  always #5 clk_in = ~clk_in;

  lms_tap_sequencer #(
    .NUM_TAPS (N),
    .MEM_LAT  (L)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .ready_in        (ready_in),
    .adapt_en_in     (adapt_en_in),
    .x_wr_en_out     (x_wr_en_out),
    .x_wr_addr_out   (x_wr_addr_out),
    .x_rd_addr_out   (x_rd_addr_out),
    .w_rd_addr_out   (w_rd_addr_out),
    .w_wr_en_out     (w_wr_en_out),
    .w_wr_addr_out   (w_wr_addr_out),
    .mac_clr_out     (mac_clr_out),
    .mac_en_out      (mac_en_out),
    .err_latch_out   (err_latch_out),
    .y_valid_out     (y_valid_out),
    .busy_out        (busy_out),
    .overrun_out     (overrun_out),
    .overrun_cnt_out (overrun_cnt_out)
  );

  int checks = 0;
  int errors = 0;
  int t = 0;

  bit m_valid = 0, m_active = 0, m_dec_known = 0, m_adapt = 0, m_opend = 0;
  int m_t0 = 0, m_last = 0, m_head = 0, m_ocnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, t, got, exp);
    end
  endtask

  // One clock cycle: compare outputs of this cycle, drive inputs, advance the model.
  task automatic step(input bit rdy, input bit adp, input bit rs);
    int off;
    int k;
    bit busy, xw, clr, mac, ev, ww;
    int e_xwa, e_xra, e_wra, e_wwa;
    off = m_active ? (t - m_t0) : 0;
    if (m_active && m_dec_known && off > m_last) begin
      m_active = 0;
      m_head   = (m_head + 1) % N;
      off      = 0;
    end
    busy = m_active && off >= 1 && (off <= E || (m_dec_known && off <= m_last));
    xw = 0; clr = 0; mac = 0; ev = 0; ww = 0;
    e_xwa = 0; e_xra = 0; e_wra = 0; e_wwa = 0;
    if (m_active) begin
      if (off == 1) begin
        xw = 1; clr = 1; e_xwa = m_head;
      end
      if (off >= 2 && off <= N + 1) begin
        k = off - 2;
        e_xra = (m_head - k + N) % N;
        e_wra = k;
      end
      if (off >= 2 + L && off <= N + 1 + L) mac = 1;
      if (off == E) ev = 1;
      if (m_dec_known && m_adapt) begin
        if (off >= E + 1 && off <= E + N) begin
          k = off - E - 1;
          e_xra = (m_head - k + N) % N;
          e_wra = k;
        end
        if (off >= E + 1 + L && off <= E + N + L) begin
          ww = 1; e_wwa = off - E - 1 - L;
        end
      end
    end
    if (m_valid) begin
      check("ctrl", {24'd0, x_wr_en_out, mac_clr_out, mac_en_out, err_latch_out,
                     y_valid_out, w_wr_en_out, busy_out, overrun_out},
                    {24'd0, xw, clr, mac, ev, ev, ww, busy, m_opend});
      check("x_wr_addr", 32'(x_wr_addr_out), 32'(e_xwa));
      check("x_rd_addr", 32'(x_rd_addr_out), 32'(e_xra));
      check("w_rd_addr", 32'(w_rd_addr_out), 32'(e_wra));
      check("w_wr_addr", 32'(w_wr_addr_out), 32'(e_wwa));
      check("ovr_cnt", 32'(overrun_cnt_out), 32'(m_ocnt));
    end
    ready_in    = rdy;
    adapt_en_in = adp;
    rst_in      = rs;
    if (rs) begin
      m_active = 0; m_head = 0; m_ocnt = 0; m_opend = 0; m_valid = 1;
    end else begin
      if (m_active && off == E && !m_dec_known) begin
        m_dec_known = 1;
        m_adapt     = adp;
        m_last      = adp ? (E + N + L) : E;
      end
      m_opend = rdy && busy;
      if (m_opend && m_ocnt < 255) m_ocnt++;
      if (rdy && !m_active) begin
        m_active    = 1;
        m_t0        = t;
        m_dec_known = 0;
      end
    end
    @(posedge clk_in);
    #1;
    t++;
  endtask

  initial begin
    bit rs, rdy;
    ready_in = 0; adapt_en_in = 0; rst_in = 1;
    @(posedge clk_in);
    #1;
    step(0, 0, 1);
    step(0, 0, 1);
    repeat (3) step(0, 0, 0);

    // Adapting sample with two overruns, one on the final busy cycle.
    step(1, 1, 0);
    for (int off = 1; off <= 75; off++) step(off == 20 || off == 68, 1'b1, 0);
    check("ovr_cnt_two", 32'(overrun_cnt_out), 32'd2);

    // Non-adapting sample; adapt_en toggles outside ERROR must not matter.
    step(1, 1, 0);
    for (int off = 1; off <= 40; off++) step(0, (off == E) ? 1'b0 : 1'($urandom_range(0, 1)), 0);

    // Enough samples to wrap head.
    for (int s = 0; s < 33; s++) begin
      step(1, 0, 0);
      for (int off = 1; off <= 70; off++) step(0, 1'($urandom_range(0, 1)), 0);
    end

    // Reset in the middle of UPDATE.
    step(1, 1, 0);
    for (int off = 1; off <= 39; off++) step(0, 1, 0);
    step(0, 1, 1);
    repeat (10) step(0, 1, 0);

    // Continuous ready drives the overrun counter into saturation.
    repeat (700) step(1, 1, 0);
    check("ovr_cnt_sat", 32'(overrun_cnt_out), 32'd255);
    repeat (80) step(0, 0, 0);

    // Random traffic with occasional reset.
    repeat (2500) begin
      rs  = ($urandom_range(0, 399) == 0);
      rdy = !rs && ($urandom_range(0, 29) == 0);
      step(rdy, 1'($urandom_range(0, 1)), rs);
    end
    repeat (80) step(0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
